// File: rtl/router_output_unit_if.sv
// Port bundle for router_output_unit: input-FIFO heads, pop strobes and the registered output link.
// master = the output unit itself, slave = whatever drives the FIFOs and consumes the link.
interface router_output_unit_if #(
    parameter int NumInputs = 5,
    parameter int Width     = 66
);
    localparam int OwnerW = $clog2(NumInputs);

    logic [NumInputs-1:0]            fifo_empty;
    logic [NumInputs-1:0][Width-1:0] fifo_data;
    logic [NumInputs-1:0]            fifo_rdreq;
    logic [Width-1:0]                out_data;
    logic                            out_void;
    logic                            out_stop;
    logic                            locked;
    logic [OwnerW-1:0]               owner;
    logic [15:0]                     pkt_count;

    modport master (
        input  fifo_empty, fifo_data, out_stop,
        output fifo_rdreq, out_data, out_void, locked, owner, pkt_count
    );

    modport slave (
        output fifo_empty, fifo_data, out_stop,
        input  fifo_rdreq, out_data, out_void, locked, owner, pkt_count
    );
endinterface

// File: rtl/router_output_unit.sv
// Wormhole output port: round-robin grant among input FIFO headers, lock until tail, registered link.
// Optional packet counter enabled by defining ROUTER_OUTPUT_UNIT_STATS_EN.
module router_output_unit #(
    parameter int NumInputs = 5,
    parameter int Width     = 66,
    parameter int Direction = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    router_output_unit_if.master  link
);
    localparam int         OwnerW   = $clog2(NumInputs);
    localparam logic [1:0] TypeTail = 2'b01;
    localparam logic [1:0] TypeHead = 2'b10;

    typedef enum logic {StIdle, StLocked} state_t;

    state_t              r_state;
    logic [OwnerW-1:0]   r_owner;
    logic [OwnerW-1:0]   r_rr;
    logic [Width-1:0]    r_outData;
    logic                r_outVoid;

    logic [NumInputs-1:0] w_request;
    logic                 w_slotFree;
    logic                 w_pop;
    logic [OwnerW-1:0]    w_popIdx;
    logic [Width-1:0]     w_popData;
    logic [1:0]           w_popType;
    logic [OwnerW-1:0]    w_nextRr;
    logic [NumInputs-1:0] w_rdreq;

    assign w_slotFree = r_outVoid | ~link.out_stop;

    // An input requests only with a header (type 10 or 11) routed to this output.
    always_comb begin
        w_request = '0;
        for (int i = 0; i < NumInputs; i++) begin
            w_request[i] = ~link.fifo_empty[i] & link.fifo_data[i][Width-1]
                           & link.fifo_data[i][Direction];
        end
    end

    // Scanning from the far end down lets the requester closest to rr win the last write.
    always_comb begin
        int scanIdx;
        scanIdx  = 0;
        w_pop    = 1'b0;
        w_popIdx = '0;
        if (r_state == StLocked) begin
            w_popIdx = r_owner;
            w_pop    = ~link.fifo_empty[r_owner] & w_slotFree;
        end else begin
            for (int k = NumInputs - 1; k >= 0; k--) begin
                scanIdx = int'(r_rr) + k;
                if (scanIdx >= NumInputs) begin
                    scanIdx = scanIdx - NumInputs;
                end
                if (w_request[scanIdx]) begin
                    w_pop    = w_slotFree;
                    w_popIdx = OwnerW'(scanIdx);
                end
            end
        end
    end

    assign w_popData = link.fifo_data[w_popIdx];
    assign w_popType = w_popData[Width-1 -: 2];
    assign w_nextRr  = (w_popIdx == OwnerW'(NumInputs - 1)) ? '0 : w_popIdx + OwnerW'(1);

    always_comb begin
        w_rdreq = '0;
        if (w_pop && !rst) begin
            w_rdreq[w_popIdx] = 1'b1;
        end
    end

    // Output register plus lock state; a header showing up at the owner while locked is treated as body.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_owner   <= '0;
            r_rr      <= '0;
            r_outData <= '0;
            r_outVoid <= 1'b1;
        end else begin
            if (w_pop) begin
                r_outData <= w_popData;
                r_outVoid <= 1'b0;
            end else if (!link.out_stop) begin
                r_outVoid <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_rr <= w_nextRr;
                        if (w_popType == TypeHead) begin
                            r_state <= StLocked;
                            r_owner <= w_popIdx;
                        end
                    end
                end
                StLocked: begin
                    if (w_pop && w_popType == TypeTail) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef ROUTER_OUTPUT_UNIT_STATS_EN
    logic [15:0] r_pktCount;

    // Tail (01) and single-flit (11) types both have the low type bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pktCount <= '0;
        end else if (w_pop && w_popType[0]) begin
            r_pktCount <= r_pktCount + 16'd1;
        end
    end

    assign link.pkt_count = r_pktCount;
`else
    assign link.pkt_count = '0;
`endif

    assign link.fifo_rdreq = w_rdreq;
    assign link.out_data   = r_outData;
    assign link.out_void   = r_outVoid;
    assign link.locked     = (r_state == StLocked);
    assign link.owner      = r_owner;
endmodule

// File: tb/tb_router_output_unit.sv
// Directed bench for router_output_unit: queue-modelled input FIFOs and a scoreboard of expected link flits.
module tb_router_output_unit;
    localparam int NI = 5;
    localparam int W  = 66;
`ifdef ROUTER_OUTPUT_UNIT_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    typedef logic [W-1:0] flit_t;

    logic clk = 1'b0;
    logic rst;

    router_output_unit_if #(.NumInputs(NI), .Width(W)) link ();

    router_output_unit #(.NumInputs(NI), .Width(W), .Direction(0)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    always #5 clk = ~clk;

    flit_t        fq [NI][$];
    flit_t        expQ [$];
    int           nCompared = 0;
    int           nMismatched = 0;
    int           expPkts = 0;
    logic [NI-1:0] sRdreq;
    logic         sVoid;
    logic         sLocked;
    logic [2:0]   sOwner;
    logic [15:0]  sPkt;
    flit_t        sData;
    logic         prevPop;
    flit_t        prevData;
    int           rrOrder [6] = '{0, 1, 4, 0, 1, 4};

    function automatic flit_t mk(input logic [1:0] ftype, input int src, input int seq, input logic route);
        flit_t f;
        f           = '0;
        f[W-1 -: 2] = ftype;
        f[47:16]    = 32'hC0DE_0000 ^ (src * 32'h0101_0000) ^ seq;
        f[15:8]     = src[7:0];
        f[7:4]      = seq[3:0];
        f[3:0]      = route ? 4'b0001 : 4'b0000;
        return f;
    endfunction

    function automatic logic [15:0] pktExp();
        return StatsEn ? 16'(expPkts) : 16'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NI; i++) begin
            link.fifo_empty[i] = (fq[i].size() == 0);
            link.fifo_data[i]  = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    endtask

    task automatic feed(input int idx, input flit_t f);
        fq[idx].push_back(f);
        applyStimulus();
    endtask

    task automatic expectFlit(input flit_t f);
        expQ.push_back(f);
    endtask

    task automatic clearModel();
        for (int i = 0; i < NI; i++) begin
            fq[i].delete();
        end
        expQ.delete();
        applyStimulus();
    endtask

    // One cycle: sample and check at the falling edge, then retire popped FIFO entries after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (prevPop) begin
            checkOutput("pop_latency_void", link.out_void, 1'b0);
            checkOutput("pop_latency_data", link.out_data, prevData);
        end
        if (!rst && !link.out_void && !link.out_stop) begin
            checkOutput("sb_pending", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
                checkOutput("sb_flit", link.out_data, expQ.pop_front());
            end
        end
        sRdreq  = link.fifo_rdreq;
        sVoid   = link.out_void;
        sData   = link.out_data;
        sLocked = link.locked;
        sOwner  = link.owner;
        sPkt    = link.pkt_count;
        checkOutput("rdreq_onehot", $onehot0(link.fifo_rdreq), 1'b1);
        checkOutput("rdreq_empty", |(link.fifo_rdreq & link.fifo_empty), 1'b0);
        if (rst) begin
            checkOutput("rdreq_in_reset", link.fifo_rdreq, '0);
        end
        prevPop  = !rst && (link.fifo_rdreq != '0);
        prevData = '0;
        for (int i = 0; i < NI; i++) begin
            if (link.fifo_rdreq[i] && fq[i].size() != 0) begin
                prevData = fq[i][0];
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (sRdreq[i] && fq[i].size() != 0) begin
                void'(fq[i].pop_front());
            end
        end
        applyStimulus();
    endtask

    initial begin
        flit_t sf, h0, b01, b02, t0, h1, t1, bh, bb0, bb1, bb2, bt, h3, b3, t3, s1;
        int    n0, tailTick, firstIn1;

        rst           = 1'b1;
        link.out_stop = 1'b0;
        prevPop       = 1'b0;
        clearModel();

        // Single-flit packet from input 2, present while reset is still asserted
        sf = mk(2'b11, 2, 0, 1'b1);
        feed(2, sf);
        expectFlit(sf);
        repeat (3) tick();
        checkOutput("reset_void", sVoid, 1'b1);
        checkOutput("reset_data", sData, '0);
        checkOutput("reset_locked", sLocked, 1'b0);
        checkOutput("reset_owner", sOwner, 3'd0);
        checkOutput("reset_pkt", sPkt, 16'd0);
        checkOutput("reset_rdreq", sRdreq, 5'b00000);
        rst = 1'b0;
        tick();
        checkOutput("single_rdreq", sRdreq, 5'b00100);
        tick();
        expPkts = 1;
        checkOutput("single_void", sVoid, 1'b0);
        checkOutput("single_data", sData, sf);
        checkOutput("single_locked", sLocked, 1'b0);
        checkOutput("single_pkt", sPkt, pktExp());

        // Wormhole lock: input 1's header must wait for input 0's tail
        h0  = mk(2'b10, 0, 0, 1'b1);
        b01 = mk(2'b00, 0, 1, 1'b0);
        b02 = mk(2'b00, 0, 2, 1'b0);
        t0  = mk(2'b01, 0, 3, 1'b0);
        h1  = mk(2'b10, 1, 0, 1'b1);
        t1  = mk(2'b01, 1, 1, 1'b0);
        feed(0, h0); feed(0, b01); feed(0, b02); feed(0, t0);
        expectFlit(h0); expectFlit(b01); expectFlit(b02); expectFlit(t0);
        expectFlit(h1); expectFlit(t1);
        n0 = 0; tailTick = -1; firstIn1 = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                feed(1, h1);
                feed(1, t1);
            end
            if (sRdreq[0]) begin
                n0++;
                if (n0 == 4) tailTick = k;
            end
            if (sRdreq[1] && firstIn1 < 0) firstIn1 = k;
            if (k == 2) begin
                checkOutput("worm_locked", sLocked, 1'b1);
                checkOutput("worm_owner", sOwner, 3'd0);
            end
        end
        expPkts = 3;
        checkOutput("worm_in0_pops", n0, 4);
        checkOutput("worm_in1_after_tail", firstIn1, tailTick + 1);
        checkOutput("worm_unlocked", sLocked, 1'b0);
        checkOutput("worm_pkt", sPkt, pktExp());

        // Backpressure held for three cycles while a body flit sits on the link
        bh  = mk(2'b10, 2, 0, 1'b1);
        bb0 = mk(2'b00, 2, 1, 1'b0);
        bb1 = mk(2'b00, 2, 2, 1'b0);
        bb2 = mk(2'b00, 2, 3, 1'b0);
        bt  = mk(2'b01, 2, 4, 1'b0);
        feed(2, bh); feed(2, bb0); feed(2, bb1); feed(2, bb2); feed(2, bt);
        expectFlit(bh); expectFlit(bb0); expectFlit(bb1); expectFlit(bb2); expectFlit(bt);
        tick();
        tick();
        link.out_stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_rdreq", sRdreq, 5'b00000);
            checkOutput("bp_void", sVoid, 1'b0);
            checkOutput("bp_data", sData, bb0);
        end
        link.out_stop = 1'b0;
        tick();
        checkOutput("bp_resume", sRdreq, 5'b00100);
        repeat (4) tick();
        expPkts = 4;
        checkOutput("bp_unlocked", sLocked, 1'b0);
        checkOutput("bp_pkt", sPkt, pktExp());

        // Owner starvation: input 3 locks then runs dry while input 1 waits with a header
        h3 = mk(2'b10, 3, 0, 1'b1);
        b3 = mk(2'b00, 3, 1, 1'b0);
        t3 = mk(2'b01, 3, 2, 1'b0);
        s1 = mk(2'b11, 1, 5, 1'b1);
        feed(3, h3);
        feed(1, s1);
        expectFlit(h3);
        tick();
        checkOutput("starve_grant", sRdreq, 5'b01000);
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("starve_void", sVoid, 1'b1);
            checkOutput("starve_locked", sLocked, 1'b1);
            checkOutput("starve_owner", sOwner, 3'd3);
            checkOutput("starve_rdreq", sRdreq, 5'b00000);
        end
        feed(3, b3);
        feed(3, t3);
        expectFlit(b3); expectFlit(t3); expectFlit(s1);
        tick();
        checkOutput("starve_body_pop", sRdreq, 5'b01000);
        repeat (4) tick();
        expPkts = 6;
        checkOutput("starve_pkt", sPkt, pktExp());

        // Reset while locked with a valid flit on the link
        feed(0, mk(2'b10, 0, 8, 1'b1));
        for (int s = 9; s < 13; s++) begin
            feed(0, mk(2'b00, 0, s, 1'b0));
        end
        feed(0, mk(2'b01, 0, 13, 1'b0));
        expectFlit(fq[0][0]);
        expectFlit(fq[0][1]);
        tick();
        tick();
        checkOutput("rst_pre_locked", sLocked, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("rst_rdreq_forced", sRdreq, 5'b00000);
        clearModel();
        tick();
        expPkts = 0;
        checkOutput("rst_void", sVoid, 1'b1);
        checkOutput("rst_locked", sLocked, 1'b0);
        checkOutput("rst_owner", sOwner, 3'd0);
        checkOutput("rst_data", sData, '0);
        checkOutput("rst_rdreq", sRdreq, 5'b00000);
        checkOutput("rst_pkt", sPkt, pktExp());
        rst = 1'b0;

        // Round-robin from a freshly reset pointer among inputs 0, 1 and 4
        for (int r = 0; r < 2; r++) begin
            feed(0, mk(2'b11, 0, r, 1'b1));
            feed(1, mk(2'b11, 1, r, 1'b1));
            feed(4, mk(2'b11, 4, r, 1'b1));
            expectFlit(mk(2'b11, 0, r, 1'b1));
            expectFlit(mk(2'b11, 1, r, 1'b1));
            expectFlit(mk(2'b11, 4, r, 1'b1));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("rr_grant", sRdreq, NI'(1) << rrOrder[k]);
            checkOutput("rr_locked", sLocked, 1'b0);
        end
        repeat (3) tick();
        expPkts = 6;
        checkOutput("rr_pkt", sPkt, pktExp());
        checkOutput("sb_drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/router_output_unit.md
# router_output_unit

Wormhole output-port unit for the packet-switched router. Sits directly downstream of the per-input-port `router_fifo` instances. It arbitrates round-robin among input FIFOs whose head header flit targets this output, then locks the output to the winner until its tail flit passes. Granted flits are popped into a single output register that drives the link, with stop-based backpressure.

## Interface
Parameters:
- `NumInputs`, 5, number of input FIFOs (N, S, W, E, Local); 2..8.
- `Width`, 66, flit width, equal to FIFO `Width`.
- `Direction`, 0, header route bit (0..3) that selects this output; route field is `data[3:0]`, one-hot.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `fifo_empty`  in  NumInputs  `empty` of each input FIFO.
- `fifo_data`  in  NumInputs×Width  `data_out` of each input FIFO.
- `fifo_rdreq`  out  NumInputs  pop to each input FIFO; at most one bit high.
- `out_data`  out  Width  registered flit to link.
- `out_void`  out  1  1 = `out_data` not valid.
- `out_stop`  in  1  downstream backpressure; 1 = hold current flit.
- `locked`  out  1  output reserved by a packet in flight.
- `owner`  out  $clog2(NumInputs)  index of locked input.
- `pkt_count`  out  16  completed packets (see Configuration).

## Operation
- Flit type is `data[Width-1:Width-2]`: 10 = header, 00 = body, 01 = tail, 11 = single-flit packet (header+tail).
- Input i requests when all of: `!fifo_empty[i]`, head type is 10 or 11, and `data[Direction]`=1.
- Slot free: `slot_free = out_void | !out_stop`.
- **State IDLE (`locked`=0):**
  - If any request and `slot_free`, grant the first requester at or after round-robin pointer `rr` (wrapping).
  - Pop it: `fifo_rdreq[g]`=1.
  - Load the flit into the output register.
  - `rr <= (g+1) mod NumInputs`.
  - Type 10 → LOCKED, `owner <= g`. Type 11 → stay IDLE.
- **State LOCKED:**
  - Only `owner` is served.
  - If `!fifo_empty[owner]` and `slot_free`, pop and load.
  - Popped type 01 → IDLE.
  - Headers from other inputs are ignored.
  - Body/tail at an unlocked input is never popped.
  - A type 10/11 head at the owner while LOCKED is a protocol error; it is forwarded as body and the lock is held.
- **Output register:**
  - Loads on every pop; `out_void <= 0`.
  - If no pop and `!out_stop`: `out_void <= 1`, data held.
  - If `out_stop`=1 and `out_void`=0: register holds.
- `rr` is unchanged while LOCKED or when no grant occurs.
- Mid-operation reset discards the lock, output flit, and `rr`; input FIFOs are reset by their own `rst`.

## Timing
- Reset values:
  - `out_void`=1, `out_data`=0, `locked`=0, `owner`=0, `rr`=0, `pkt_count`=0.
  - `fifo_rdreq`=0 during `rst` (combinational, forced).
- `fifo_rdreq` is combinational from state, `fifo_empty`, `fifo_data`, `out_stop`. It is never high for an empty FIFO.
- Latency: pop in cycle t → `out_data` valid, `out_void`=0 in t+1.
- Throughput: 1 flit/cycle while `out_stop`=0 and owner non-empty.
- Tail popped in t: unlock in t+1. The next header can be granted in t+1 (no bubble). Single-flit packets grant back-to-back.
- `out_stop` high in t with a valid flit: no pop in t, `out_data` stable into t+1.
- Owner FIFO empty mid-packet: no pop, `out_void` → 1 next cycle (if `!out_stop`), lock held.

## Configuration
- Macro: `ROUTER_OUTPUT_UNIT_STATS_EN`.
- **Defined:**
  - `pkt_count` increments (wraps at 16 bits) in the cycle after a type 01 or type 11 flit is popped.
  - Reset value is 0.
- **Undefined:** no counter logic; `pkt_count` tied to 0.

## Test plan
- **Single-flit packet:** reset; input 2 head = type 11, route bit set.
  - `fifo_rdreq`=0b00100 for 1 cycle.
  - Next cycle `out_void`=0, data matches.
  - `locked` stays 0; `pkt_count`=1 (STATS_EN).
- **Wormhole lock:** input 0 sends header, 2 bodies, tail.
  - Input 1 presents a header from cycle 1; input 1 is not popped until the cycle after input 0's tail pop.
  - Output shows 4 flits of input 0, then input 1's header.
- **Round-robin:** inputs 0, 1, 4 hold type 11 heads continuously.
  - Grant order 0, 1, 4, 0, 1, 4 on consecutive cycles.
- **Backpressure:** `out_stop`=1 for 3 cycles during a body flit.
  - `out_data` is constant and no `fifo_rdreq` for those cycles.
  - Popping resumes the cycle `out_stop` falls.
- **Owner starvation:** owner FIFO goes empty after its header.
  - `out_void`=1, `locked`=1, and other inputs not popped.
  - Body arrives later and is forwarded.
- **Reset mid-packet:** assert `rst` while LOCKED with a valid output.
  - Next cycle `out_void`=1, `locked`=0, `rr`=0, `fifo_rdreq`=0.
